btn_debouncer: RTL and testbench
================================

BTN_DEBOUNCER -- requirements
Module: btn_debouncer

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels (1..32).
REQ-002 Parameter DIV, default 256: clk cycles per sample tick (>=2).
REQ-003 Parameter STABLE_CNT, default 3: consecutive differing samples needed to accept a new level (1..15).
REQ-004 Parameter LONG_TICKS, default 40: ticks of continuous pressed level before long-press (>=1); used only with BTN_LONG_PRESS_EN.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in  input  N_CH  raw asynchronous button levels, 1 = pressed.
REQ-008 level  output  N_CH  debounced level per channel, registered.
REQ-009 press  output  N_CH  one-clk pulse when level goes 0->1.
REQ-010 release  output  N_CH  one-clk pulse when level goes 1->0.
REQ-011 long_press  output  N_CH  one-clk pulse on long-press; constant 0 without BTN_LONG_PRESS_EN.

Function
REQ-012 Each in bit passes through a 2-flop synchroniser on clk; all later logic uses the synchronised value only.
REQ-013 Shared tick counter, width $clog2(DIV), counts 0..DIV-1 and wraps; tick is high for exactly one clk when counter == DIV-1.
REQ-014 Per channel on tick: sample != level -> stability count +1; sample == level -> stability count cleared to 0.
REQ-015 When a tick brings the count to STABLE_CNT: level inverts on that clk edge, count clears, and press (new level 1) or release (new level 0) is high for the following single clk only.
REQ-016 Between ticks, level, counts and the long-press state hold; glitches shorter than one tick interval not sampled are ignored entirely.
REQ-017 A sample matching level on any tick aborts the pending change (bounce); no pulse is generated.
REQ-018 Latency from stable change on in to level change: min 2+(STABLE_CNT-1)*DIV+1, max 2+STABLE_CNT*DIV clk cycles.
REQ-019 press and release are never high together on one channel; channels are fully independent and may pulse in the same cycle.
REQ-020 Stability count width is 4 bits and cannot exceed STABLE_CNT.

Reset
REQ-021 While rst is high on a clk edge: synchronisers, tick counter, stability counts, long-press counters cleared; level, press, release, long_press = 0.
REQ-022 First possible tick after rst deassertion is DIV clk cycles later; a channel held pressed through reset produces press after normal debouncing.
REQ-023 rst asserted mid-debounce or mid-long-press discards the pending event; no pulse in the cycle after reset release.

Configuration
REQ-024 Macro BTN_LONG_PRESS_EN: when defined, per-channel long-press counter (width $clog2(LONG_TICKS+1)) increments on each tick while level=1, saturates, and long_press pulses one clk exactly when it reaches LONG_TICKS; counter clears when level=0; at most one long_press per press.
REQ-025 Without BTN_LONG_PRESS_EN: no long-press counters are synthesised; long_press tied to 0; LONG_TICKS ignored.

Structure
REQ-026 Package btn_pkg holds default parameter constants (N_CH, DIV, STABLE_CNT, LONG_TICKS) and the stability count width constant.
REQ-027 Sub-module btn_db_chan: one channel's synchroniser, stability counter, level, pulses and optional long-press; instantiated N_CH times via generate; tick counter stays in top.

Verification (DIV=4, STABLE_CNT=3, LONG_TICKS=5, N_CH=4)
REQ-028 in[0] 0->1 held clean -> level[0]=1 and single press[0] within 11..14 clk; release after 0 held likewise.
REQ-029 in[1] pulse 1 clk wide between ticks -> level[1], press[1] stay 0.
REQ-030 in[2] high for 2 ticks, low 1 tick, high steady -> no early transition; press[2] only after 3 consecutive high samples.
REQ-031 in=4'b1111 applied once -> press=4'b1111 in the same cycle; levels all 1.
REQ-032 in[3] high, rst pulsed 1 clk after 2 high samples -> all outputs 0; press[3] follows a full fresh debounce after reset.
REQ-033 With BTN_LONG_PRESS_EN, in[0] held high -> long_press[0] exactly once, 5 ticks after press[0]; none without macro.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared defaults for the multi-channel button debouncer.
// Width of the per-channel stability counter lives here too.
package btn_pkg;

    localparam int N_CH_DEF       = 4;
    localparam int DIV_DEF        = 256;
    localparam int STABLE_CNT_DEF = 3;
    localparam int LONG_TICKS_DEF = 40;
    localparam int CNT_W          = 4;

endpackage

// File: rtl/btn_db_chan.sv
// One debounce channel: synchroniser, stability counter, level and pulses.
// Long-press detection is built only when BTN_LONG_PRESS_EN is defined.
module btn_db_chan
    import btn_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_CNT_DEF,
    parameter int LONG_TICKS = LONG_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic in,
    output logic level,
    output logic press,
    output logic released,
    output logic long_press
);

    if (STABLE_CNT < 1 || STABLE_CNT > 15) begin : g_bad_stable
        $error("STABLE_CNT out of range");
    end
    if (LONG_TICKS < 1) begin : g_bad_long
        $error("LONG_TICKS must be >= 1");
    end

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             hit;

    // Final differing sample of a run: the level flips on this edge.
    assign hit = tick && (s2 != level)
              && ((cnt + 1'b1) == CNT_W'(STABLE_CNT));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            cnt      <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
        end else begin
            s1       <= in;
            s2       <= s1;
            press    <= 1'b0;
            released <= 1'b0;
            if (tick) begin
                if (s2 == level) begin
                    cnt <= '0;
                end else if (hit) begin
                    cnt      <= '0;
                    level    <= ~level;
                    press    <= ~level;
                    released <= level;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_TICKS + 1);

    logic [LW-1:0] lp_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            lp_cnt     <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (!level) begin
                lp_cnt <= '0;
            end else if (tick && lp_cnt != LW'(LONG_TICKS)) begin
                lp_cnt     <= lp_cnt + 1'b1;
                long_press <= ((lp_cnt + 1'b1) == LW'(LONG_TICKS));
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/btn_debouncer.sv
// N-channel button debouncer with a shared sample tick.
// Define BTN_LONG_PRESS_EN to enable per-channel long-press pulses.
module btn_debouncer
    import btn_pkg::*;
#(
    parameter int N_CH       = N_CH_DEF,
    parameter int DIV        = DIV_DEF,
    parameter int STABLE_CNT = STABLE_CNT_DEF,
    parameter int LONG_TICKS = LONG_TICKS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] released,
    output logic [N_CH-1:0] long_press
);

    if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
        $error("N_CH out of range");
    end
    if (DIV < 2) begin : g_bad_div
        $error("DIV must be >= 2");
    end

    localparam int TW = $clog2(DIV);

    logic [TW-1:0] div_cnt;
    logic          tick;

    assign tick = (div_cnt == TW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        btn_db_chan #(
            .STABLE_CNT (STABLE_CNT),
            .LONG_TICKS (LONG_TICKS)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .in         (in[i]),
            .level      (level[i]),
            .press      (press[i]),
            .released   (released[i]),
            .long_press (long_press[i])
        );
    end

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with DIV=4, STABLE_CNT=3, LONG_TICKS=5.
// Build with BTN_LONG_PRESS_EN defined to exercise the long-press test.
module tb_btn_debouncer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in  = 4'b0000;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] released;
    logic [3:0] long_press;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    int lp_seen = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    btn_debouncer #(
        .N_CH       (4),
        .DIV        (4),
        .STABLE_CNT (3),
        .LONG_TICKS (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .level      (level),
        .press      (press),
        .released   (released),
        .long_press (long_press)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            lp_seen += $countones(long_press);
            if ((press & released) != 4'b0000) overlap++;
        end
    end

    // Observe one channel for n cycles; k counts clk edges since the call.
    task automatic watch(input int ch, input int n,
                         output int chg, output int fp, output int fr,
                         output int np, output int nr);
        logic l0;
        l0  = level[ch];
        chg = -1; fp = -1; fr = -1; np = 0; nr = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (chg < 0 && level[ch] !== l0) chg = k;
            if (press[ch] === 1'b1) begin
                np++;
                if (fp < 0) fp = k;
            end
            if (released[ch] === 1'b1) begin
                nr++;
                if (fr < 0) fr = k;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (level !== 4'b0000) begin
            errors++;
            $display("FAIL reset_level got=%b want=0000", level);
        end
        checks++;
        if (press !== 4'b0000) begin
            errors++;
            $display("FAIL reset_press got=%b want=0000", press);
        end
        checks++;
        if (released !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release got=%b want=0000", released);
        end
        checks++;
        if (long_press !== 4'b0000) begin
            errors++;
            $display("FAIL reset_long got=%b want=0000", long_press);
        end
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_press_release();
        int chg, fp, fr, np, nr;
        in[0] = 1'b1;
        watch(0, 20, chg, fp, fr, np, nr);
        checks++;
        if (chg < 11 || chg > 14) begin
            errors++;
            $display("FAIL press_latency got=%0d want=11..14", chg);
        end
        checks++;
        if (np != 1 || fp != chg || nr != 0) begin
            errors++;
            $display("FAIL press_pulse got np=%0d fp=%0d nr=%0d want 1,%0d,0",
                     np, fp, nr, chg);
        end
        in[0] = 1'b0;
        watch(0, 20, chg, fp, fr, np, nr);
        checks++;
        if (chg < 11 || chg > 14) begin
            errors++;
            $display("FAIL release_latency got=%0d want=11..14", chg);
        end
        checks++;
        if (nr != 1 || fr != chg || np != 0) begin
            errors++;
            $display("FAIL release_pulse got nr=%0d fr=%0d np=%0d want 1,%0d,0",
                     nr, fr, np, chg);
        end
    endtask

    task automatic test_glitch();
        int chg, fp, fr, np, nr;
        in[1] = 1'b1;
        @(negedge clk);
        in[1] = 1'b0;
        watch(1, 30, chg, fp, fr, np, nr);
        checks++;
        if (chg != -1 || level[1] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_level got chg=%0d lvl=%b want none,0",
                     chg, level[1]);
        end
        checks++;
        if (np != 0 || nr != 0) begin
            errors++;
            $display("FAIL glitch_pulse got np=%0d nr=%0d want 0,0", np, nr);
        end
    endtask

    task automatic test_bounce();
        int chg, fp, fr, np, nr;
        in[2] = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (level[2] !== 1'b0) begin
            errors++;
            $display("FAIL bounce_high got=%b want=0", level[2]);
        end
        in[2] = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (level[2] !== 1'b0 || press[2] !== 1'b0) begin
            errors++;
            $display("FAIL bounce_low got lvl=%b pr=%b want 0,0",
                     level[2], press[2]);
        end
        in[2] = 1'b1;
        watch(2, 20, chg, fp, fr, np, nr);
        checks++;
        if (chg < 11 || chg > 14 || fp != chg || np != 1) begin
            errors++;
            $display("FAIL bounce_press got chg=%0d fp=%0d np=%0d want 11..14",
                     chg, fp, np);
        end
    endtask

    task automatic test_all_channels();
        bit found;
        in = 4'b0000;
        repeat (20) @(negedge clk);
        checks++;
        if (level !== 4'b0000) begin
            errors++;
            $display("FAIL all_idle got=%b want=0000", level);
        end
        in    = 4'b1111;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (press !== 4'b0000) found = 1'b1;
        end
        checks++;
        if (!found || press !== 4'b1111) begin
            errors++;
            $display("FAIL all_press got=%b found=%0d want=1111", press, found);
        end
        checks++;
        if (level !== 4'b1111) begin
            errors++;
            $display("FAIL all_level got=%b want=1111", level);
        end
    endtask

    task automatic test_mid_reset();
        int chg, fp, fr, np, nr;
        in = 4'b0000;
        repeat (20) @(negedge clk);
        in = 4'b1000;
        repeat (10) @(negedge clk);
        checks++;
        if (level[3] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre got=%b want=0", level[3]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({level, press, released, long_press} !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_clear got=%h want=0000",
                     {level, press, released, long_press});
        end
        rst = 1'b0;
        watch(3, 20, chg, fp, fr, np, nr);
        checks++;
        if (chg != 12 || fp != 12 || np != 1) begin
            errors++;
            $display("FAIL midrst_fresh got chg=%0d fp=%0d np=%0d want 12,12,1",
                     chg, fp, np);
        end
    endtask

`ifdef BTN_LONG_PRESS_EN
    task automatic test_long_press();
        int kp, kl, n;
        in = 4'b0000;
        repeat (20) @(negedge clk);
        in = 4'b0001;
        kp = -1; kl = -1; n = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (press[0] === 1'b1 && kp < 0) kp = k;
            if (long_press[0] === 1'b1) begin
                n++;
                if (kl < 0) kl = k;
            end
        end
        checks++;
        if (kp < 0 || kl - kp != 20) begin
            errors++;
            $display("FAIL long_delay got kp=%0d kl=%0d want kl-kp=20", kp, kl);
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL long_count got=%0d want=1", n);
        end
    endtask
`else
    task automatic test_long_press();
        in = 4'b1111;
        repeat (60) @(negedge clk);
        checks++;
        if (lp_seen != 0) begin
            errors++;
            $display("FAIL long_off got=%0d want=0", lp_seen);
        end
    endtask
`endif

    task automatic test_exclusive();
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL press_release_overlap got=%0d want=0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_glitch();
        test_bounce();
        test_all_channels();
        test_mid_reset();
        test_long_press();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
